// File: rtl/pc_select_unit.sv
// Next-PC selector: prioritised redirect, stall hold, one-deep pending redirect.
// Optional return-address stack enabled by defining PC_SEL_RAS_EN.
module pc_select_unit #(
    parameter int unsigned    AW        = 6,
    parameter logic [AW-1:0] RST_VEC   = '0,
    parameter logic [AW-1:0] EXC_VEC   = {AW{1'b1}},
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_target,
    input  logic          exc,
    input  logic          call,
    input  logic          ret,
    output logic [AW-1:0] pc,
    output logic          redirect_pend,
    output logic          ras_empty,
    output logic          ras_full
);

    logic [AW-1:0] pc_q, pc_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [AW-1:0] pc_inc;
    logic          ret_v;
    logic [AW-1:0] ras_top;
    logic          has_redir;
    logic [AW-1:0] redir_tgt;

    assign pc_inc = pc_q + 1'b1;

`ifdef PC_SEL_RAS_EN
    localparam int LW = $clog2(RAS_DEPTH);
    localparam logic [LW:0] FULL_CNT = (LW+1)'(RAS_DEPTH);

    logic [AW-1:0] ras_q [RAS_DEPTH];
    logic [AW-1:0] ras_d [RAS_DEPTH];
    logic [LW-1:0] sp_q, sp_d;
    logic [LW:0]   cnt_q, cnt_d;
    logic [LW-1:0] top_idx;
    logic          call_v;

    // sp_q points at the next free slot; the stack wraps when full
    assign top_idx = sp_q - 1'b1;
    assign ras_top = ras_q[top_idx];
    assign ret_v   = ret & (cnt_q != '0) & ~stall & ~exc;
    assign call_v  = call & ~stall & ~exc;

    always_comb begin
        ras_d = ras_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (call_v && ret_v) begin
            ras_d[top_idx] = pc_inc;
        end else if (call_v) begin
            ras_d[sp_q] = pc_inc;
            sp_d        = sp_q + 1'b1;
            if (cnt_q != FULL_CNT)
                cnt_d = cnt_q + 1'b1;
        end else if (ret_v) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ras_q <= ras_d;
        end
    end

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);
`else
    logic unused_ras;
    assign unused_ras = call ^ ret ^ (RAS_DEPTH == 0);
    assign ret_v      = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

    always_comb begin
        has_redir = 1'b1;
        redir_tgt = '0;
        if (ret_v)
            redir_tgt = ras_top;
        else if (jmp)
            redir_tgt = jmp_target;
        else if (br_taken)
            redir_tgt = br_target;
        else
            has_redir = 1'b0;
    end

    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (exc) begin
            pc_d   = EXC_VEC;
            pend_d = 1'b0;
        end else if (!stall) begin
            pend_d = 1'b0;
            if (has_redir)
                pc_d = redir_tgt;
            else if (pend_q)
                pc_d = pend_addr_q;
            else
                pc_d = pc_inc;
        end else if (has_redir) begin
            // latest redirect seen during a stall wins
            pend_d      = 1'b1;
            pend_addr_d = redir_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RST_VEC;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pc            = pc_q;
    assign redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_select_unit.sv
// Scoreboard bench for pc_select_unit (AW=6); RAS cases run when
// PC_SEL_RAS_EN is defined.
module tb_pc_select_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, br_taken, jmp, exc, call, ret;
    logic [5:0] br_target, jmp_target;
    logic [5:0] pc;
    logic       redirect_pend, ras_empty, ras_full;

    typedef struct {
        logic [5:0] pc;
        logic       pend;
        logic       empty;
        logic       full;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    pc_select_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target),
        .exc(exc), .call(call), .ret(ret),
        .pc(pc), .redirect_pend(redirect_pend),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive one cycle, push expectation, compare after the edge
    task automatic cyc(input string tag, input logic s,
                       input logic b, input logic [5:0] bt,
                       input logic j, input logic [5:0] jt,
                       input logic e, input logic c, input logic r,
                       input logic [5:0] epc, input logic ep,
                       input logic ee, input logic ef);
        exp_t x;
        stall = s; br_taken = b; br_target = bt;
        jmp = j; jmp_target = jt; exc = e; call = c; ret = r;
        x.pc = epc; x.pend = ep; x.empty = ee; x.full = ef;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb"}, 32'd0, 32'd1);
        end else begin
            x = sb_q.pop_front();
            chk({tag, ".pc"}, 32'(pc), 32'(x.pc));
            chk({tag, ".pend"}, 32'(redirect_pend), 32'(x.pend));
            chk({tag, ".empty"}, 32'(ras_empty), 32'(x.empty));
            chk({tag, ".full"}, 32'(ras_full), 32'(x.full));
        end
    endtask

    task automatic idle(input string tag, input logic [5:0] epc);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, epc, 0, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 1, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++)
            idle("wrap", 6'((i + 1) % 64));

        cyc("to5", 0, 1, 6'd5, 0, 0, 0, 0, 0, 6'd5, 0, 1, 0);
        cyc("prio_exc", 0, 1, 6'd9, 1, 6'd20, 1, 0, 0, 6'd63, 0, 1, 0);
        cyc("prio_jmp", 0, 1, 6'd9, 1, 6'd20, 0, 0, 0, 6'd20, 0, 1, 0);
        cyc("prio_br", 0, 1, 6'd9, 0, 0, 0, 0, 0, 6'd9, 0, 1, 0);
        idle("seq10", 6'd10);

        cyc("stl_br", 1, 1, 6'd30, 0, 0, 0, 0, 0, 6'd10, 1, 1, 0);
        cyc("stl_jmp", 1, 0, 0, 1, 6'd40, 0, 0, 0, 6'd10, 1, 1, 0);
        idle("release", 6'd40);
        idle("seq41", 6'd41);

        cyc("stl_b50", 1, 1, 6'd50, 0, 0, 0, 0, 0, 6'd41, 1, 1, 0);
        cyc("stl_hold", 1, 0, 0, 0, 0, 0, 0, 0, 6'd41, 1, 1, 0);
        cyc("new_beats", 0, 0, 0, 1, 6'd7, 0, 0, 0, 6'd7, 0, 1, 0);
        idle("seq8", 6'd8);

        cyc("stl_b20", 1, 1, 6'd20, 0, 0, 0, 0, 0, 6'd8, 1, 1, 0);
        cyc("stl_exc", 1, 0, 0, 0, 0, 1, 0, 0, 6'd63, 0, 1, 0);
        idle("post_exc", 6'd0);

        rst_n = 1'b0;
        cyc("rst_exc", 0, 0, 0, 0, 0, 1, 0, 0, 6'd0, 0, 1, 0);
        rst_n = 1'b1;

`ifdef PC_SEL_RAS_EN
        cyc("to3", 0, 1, 6'd3, 0, 0, 0, 0, 0, 6'd3, 0, 1, 0);
        cyc("call12", 0, 0, 0, 1, 6'd12, 0, 1, 0, 6'd12, 0, 0, 0);
        cyc("ret4", 0, 0, 0, 0, 0, 0, 0, 1, 6'd4, 0, 1, 0);
        cyc("ret_empty", 0, 0, 0, 0, 0, 0, 0, 1, 6'd5, 0, 1, 0);
        cyc("to1", 0, 1, 6'd1, 0, 0, 0, 0, 0, 6'd1, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            cyc("ovf_call", 0, 0, 0, 1, 6'(i + 2), 0, 1, 0,
                6'(i + 2), 0, 0, i >= 3);
        cyc("ret6", 0, 0, 0, 0, 0, 0, 0, 1, 6'd6, 0, 0, 0);
        cyc("ret5", 0, 0, 0, 0, 0, 0, 0, 1, 6'd5, 0, 0, 0);
        cyc("ret4b", 0, 0, 0, 0, 0, 0, 0, 1, 6'd4, 0, 0, 0);
        cyc("ret3", 0, 0, 0, 0, 0, 0, 0, 1, 6'd3, 0, 1, 0);
        cyc("ret_ign", 0, 0, 0, 0, 0, 0, 0, 1, 6'd4, 0, 1, 0);
        cyc("stl_call", 1, 0, 0, 1, 6'd30, 0, 1, 0, 6'd4, 1, 1, 0);
        idle("rel_call", 6'd30);
`else
        cyc("call_off", 0, 0, 0, 1, 6'd12, 0, 1, 0, 6'd12, 0, 1, 0);
        cyc("ret_off", 0, 0, 0, 0, 0, 0, 0, 1, 6'd13, 0, 1, 0);
`endif

        if (sb_q.size() != 0)
            chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
